// File: rtl/sd_block_server_pkg.sv
// Shared definitions for the SD sector server: FSM states and sector geometry.
package sd_block_server_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RD_MEM,
    RD_WAIT,
    RD_OUT,
    WR_REQ,
    WR_CAP,
    WR_MEM,
    WR_WAIT,
    DONE,
    HOLD
  } state_t;

  localparam int unsigned SECTOR_BYTES = 512;
  localparam int unsigned SECTOR_SHIFT = 9;
  localparam logic [8:0]  LAST_BYTE    = 9'(SECTOR_BYTES - 1);

endpackage

// File: rtl/sd_block_server.sv
// Serves 512-byte FDC sector reads/writes out of a byte-wide backing memory,
// with range and write-protect screening against the mounted image size.
module sd_block_server
  import sd_block_server_pkg::*;
#(
  parameter int unsigned ADDR_W     = 25,
  parameter bit          WP_DEFAULT = 1'b0
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [31:0]       sd_lba,
  input  logic              sd_rd,
  input  logic              sd_wr,
  output logic              sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic [7:0]        sd_dout,
  output logic              sd_dout_strobe,
  input  logic [7:0]        sd_din,
  output logic              sd_din_strobe,
  input  logic              img_mounted,
  input  logic [31:0]       img_size,
  input  logic              img_wp,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_d,
  input  logic [7:0]        mem_q,
  input  logic              mem_ready,
  output logic              err
);

  state_t      state;
  logic [31:0] lba_q;
  logic [31:0] size_q;
  logic        rd_q;
  logic        bypass;
  logic        req_oor;
  logic        wp_eff;
  logic        last_byte;
  logic        byte_done;

  // A sector is usable only if it lies entirely inside the image.
  assign req_oor   = sd_lba >= (size_q >> SECTOR_SHIFT);
  assign wp_eff    = img_wp | WP_DEFAULT;
  assign last_byte = (sd_buff_addr == LAST_BYTE);
  assign mem_addr  = ADDR_W'((41'(lba_q) << SECTOR_SHIFT) + 41'(sd_buff_addr));

  // One byte of the sector has been fully handed over in this cycle.
  assign byte_done = (state == RD_OUT)
                  || (state == WR_CAP && bypass)
                  || (state == WR_WAIT && mem_ready);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      lba_q          <= '0;
      size_q         <= '0;
      rd_q           <= 1'b0;
      bypass         <= 1'b0;
      sd_ack         <= 1'b0;
      sd_buff_addr   <= '0;
      sd_dout        <= '0;
      sd_dout_strobe <= 1'b0;
      sd_din_strobe  <= 1'b0;
      mem_rd         <= 1'b0;
      mem_wr         <= 1'b0;
      mem_d          <= '0;
      err            <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low each cycle with non-blocking assignments;
      // the states below only raise them for the single cycle they are owned.
      mem_rd         <= 1'b0;
      mem_wr         <= 1'b0;
      sd_dout_strobe <= 1'b0;
      sd_din_strobe  <= 1'b0;
      err            <= 1'b0;

      if (img_mounted) size_q <= img_size;

      if (byte_done) begin
        if (last_byte) begin
          sd_ack <= 1'b0;
          state  <= DONE;
        end else begin
          sd_buff_addr  <= sd_buff_addr + 9'd1;
          mem_rd        <= rd_q & ~bypass;
          sd_din_strobe <= ~rd_q;
          state         <= rd_q ? RD_MEM : WR_REQ;
        end
      end else begin
        case (state)
          IDLE: begin
            if (sd_rd || sd_wr) begin
              lba_q        <= sd_lba;
              rd_q         <= sd_rd;
              sd_ack       <= 1'b1;
              sd_buff_addr <= '0;
              if (sd_rd) begin
                bypass <= req_oor;
                err    <= req_oor;
                mem_rd <= ~req_oor;
                state  <= RD_MEM;
              end else begin
                bypass        <= req_oor | wp_eff;
                err           <= req_oor | wp_eff;
                sd_din_strobe <= 1'b1;
                state         <= WR_REQ;
              end
            end
          end
          RD_MEM: begin
            if (bypass) begin
              sd_dout        <= 8'h00;
              sd_dout_strobe <= 1'b1;
              state          <= RD_OUT;
            end else begin
              state <= RD_WAIT;
            end
          end
          RD_WAIT: begin
            if (mem_ready) begin
              sd_dout        <= mem_q;
              sd_dout_strobe <= 1'b1;
              state          <= RD_OUT;
            end
          end
          WR_REQ: state <= WR_CAP;
          WR_CAP: begin
            mem_d  <= sd_din;
            mem_wr <= 1'b1;
            state  <= WR_MEM;
          end
          WR_MEM: state <= WR_WAIT;
          DONE:   state <= HOLD;
          // A level request still high from the finished transfer must drop first.
          HOLD: begin
            if (!sd_rd && !sd_wr) state <= IDLE;
          end
          RD_OUT, WR_WAIT: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_block_server.sv
// Randomised self-checking bench for sd_block_server against a sector-level model.
module tb_sd_block_server;

  localparam int ADDR_W = 25;

  logic              clk_sys;
  logic              reset_n;
  logic [31:0]       sd_lba;
  logic              sd_rd;
  logic              sd_wr;
  logic              sd_ack;
  logic [8:0]        sd_buff_addr;
  logic [7:0]        sd_dout;
  logic              sd_dout_strobe;
  logic [7:0]        sd_din;
  logic              sd_din_strobe;
  logic              img_mounted;
  logic [31:0]       img_size;
  logic              img_wp;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [7:0]        mem_d;
  logic [7:0]        mem_q;
  logic              mem_ready;
  logic              err;

  sd_block_server #(.ADDR_W(ADDR_W), .WP_DEFAULT(1'b0)) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .sd_lba        (sd_lba),
    .sd_rd         (sd_rd),
    .sd_wr         (sd_wr),
    .sd_ack        (sd_ack),
    .sd_buff_addr  (sd_buff_addr),
    .sd_dout       (sd_dout),
    .sd_dout_strobe(sd_dout_strobe),
    .sd_din        (sd_din),
    .sd_din_strobe (sd_din_strobe),
    .img_mounted   (img_mounted),
    .img_size      (img_size),
    .img_wp        (img_wp),
    .mem_addr      (mem_addr),
    .mem_rd        (mem_rd),
    .mem_wr        (mem_wr),
    .mem_d         (mem_d),
    .mem_q         (mem_q),
    .mem_ready     (mem_ready),
    .err           (err)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  // The FDC sector buffer hands back the complement of each byte index.
  assign sd_din = ~sd_buff_addr[7:0];

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct { logic [8:0] idx; logic [7:0] data; } rd_ev_t;
  typedef struct { logic [ADDR_W-1:0] addr; logic [7:0] data; } wr_ev_t;

  rd_ev_t            exp_rd_q[$];
  logic [ADDR_W-1:0] exp_mrd_q[$];
  wr_ev_t            exp_mwr_q[$];
  logic [8:0]        exp_din_q[$];

  bit [7:0]    model_mem [0:65535];
  bit [7:0]    dev_mem   [0:65535];
  logic [31:0] m_size;
  logic [31:0] sizes [3] = '{32'd4096, 32'd3000, 32'd6144};

  int err_seen, rd_strobes, din_strobes, ack_rises, mrd_cnt;
  logic [7:0]        cap_b300, cap_b511, cap_first_wd, cap_last_wd;
  logic [ADDR_W-1:0] cap_first_wa, cap_last_wa;
  bit                wr_seen;
  bit                spurious_en;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      model_mem[i] = 8'(i);
      dev_mem[i]   = 8'(i);
    end
  end

  // Backing memory: random 1..3 cycle latency, plus stray ready pulses when idle.
  bit          pending, pend_is_rd;
  logic [15:0] pend_addr;
  int          lat;
  initial begin
    mem_ready = 1'b0;
    mem_q     = 8'h00;
    pending   = 1'b0;
    forever begin
      @(negedge clk_sys);
      mem_ready = 1'b0;
      if (!reset_n) begin
        pending = 1'b0;
      end else if (pending) begin
        if (lat == 0) begin
          mem_ready = 1'b1;
          mem_q     = pend_is_rd ? dev_mem[pend_addr] : 8'($urandom);
          pending   = 1'b0;
        end else begin
          lat--;
        end
      end else if (mem_rd || mem_wr) begin
        pending    = 1'b1;
        pend_is_rd = mem_rd;
        pend_addr  = mem_addr[15:0];
        lat        = $urandom_range(2, 0);
        if (mem_wr) dev_mem[mem_addr[15:0]] = mem_d;
      end else if (spurious_en && $urandom_range(7, 0) == 0) begin
        mem_ready = 1'b1;
        mem_q     = 8'h5A;
      end
    end
  end

  // Every-cycle compare of DUT events against the planned transfer queues.
  rd_ev_t            ce_rd;
  wr_ev_t            ce_wr;
  logic [ADDR_W-1:0] ce_a;
  logic [8:0]        ce_i;
  logic              prev_ack;
  initial begin
    prev_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        prev_ack = 1'b0;
      end else begin
        if (sd_ack && !prev_ack) ack_rises++;
        prev_ack = sd_ack;
        if (err) err_seen++;
        if (mem_rd || mem_wr || sd_dout_strobe || sd_din_strobe)
          check("strobe_exclusive",
                64'($countones({mem_rd, mem_wr, sd_dout_strobe, sd_din_strobe})), 64'd1);
        if (sd_dout_strobe) begin
          rd_strobes++;
          check("ack_during_dout", sd_ack, 1'b1);
          if (sd_buff_addr == 9'd300) cap_b300 = sd_dout;
          if (sd_buff_addr == 9'd511) cap_b511 = sd_dout;
          if (exp_rd_q.size() == 0) check("unexpected_dout", 1, 0);
          else begin
            ce_rd = exp_rd_q.pop_front();
            check("dout_index", sd_buff_addr, ce_rd.idx);
            check("dout_data", sd_dout, ce_rd.data);
          end
        end
        if (sd_din_strobe) begin
          din_strobes++;
          check("ack_during_din", sd_ack, 1'b1);
          if (exp_din_q.size() == 0) check("unexpected_din", 1, 0);
          else begin
            ce_i = exp_din_q.pop_front();
            check("din_index", sd_buff_addr, ce_i);
          end
        end
        if (mem_rd) begin
          mrd_cnt++;
          if (exp_mrd_q.size() == 0) check("unexpected_mem_rd", 1, 0);
          else begin
            ce_a = exp_mrd_q.pop_front();
            check("mem_rd_addr", mem_addr, ce_a);
          end
        end
        if (mem_wr) begin
          if (!wr_seen) begin
            cap_first_wa = mem_addr;
            cap_first_wd = mem_d;
          end
          wr_seen     = 1'b1;
          cap_last_wa = mem_addr;
          cap_last_wd = mem_d;
          if (exp_mwr_q.size() == 0) check("unexpected_mem_wr", 1, 0);
          else begin
            ce_wr = exp_mwr_q.pop_front();
            check("mem_wr_addr", mem_addr, ce_wr.addr);
            check("mem_wr_data", mem_d, ce_wr.data);
          end
        end
      end
    end
  end

  // Sector-level model: which bytes, addresses and data a transfer must produce.
  task automatic plan(input bit is_rd, input logic [31:0] lba, output bit blocked);
    logic [63:0] base;
    logic [15:0] a16;
    logic [7:0]  d;
    blocked = ((64'(lba) + 64'd1) * 64'd512 > 64'(m_size)) || (!is_rd && img_wp);
    base    = 64'(lba) * 64'd512;
    for (int i = 0; i < 512; i++) begin
      a16 = 16'(base + 64'(i));
      if (is_rd) begin
        d = blocked ? 8'h00 : model_mem[a16];
        exp_rd_q.push_back('{idx: 9'(i), data: d});
        if (!blocked) exp_mrd_q.push_back(ADDR_W'(base + 64'(i)));
      end else begin
        d = ~8'(i);
        exp_din_q.push_back(9'(i));
        if (!blocked) begin
          exp_mwr_q.push_back('{addr: ADDR_W'(base + 64'(i)), data: d});
          model_mem[a16] = d;
        end
      end
    end
  endtask

  task automatic mount(input logic [31:0] s);
    @(negedge clk_sys);
    img_size    = s;
    img_mounted = 1'b1;
    @(negedge clk_sys);
    img_mounted = 1'b0;
    m_size      = s;
  endtask

  task automatic xfer(input bit rd, input bit wr, input logic [31:0] lba, input int hold,
                      input int mount_at, input logic [31:0] mount_size);
    bit blocked;
    int rises0;
    int c;
    plan(rd, lba, blocked);
    err_seen = 0;
    rises0   = ack_rises;
    sd_lba   = lba;
    sd_rd    = rd;
    sd_wr    = wr;
    c = 0;
    while (!sd_ack && c < 10) begin
      @(negedge clk_sys);
      c++;
    end
    check("ack_rise", sd_ack, 1'b1);
    if (hold == 0) begin
      sd_rd  = 1'b0;
      sd_wr  = 1'b0;
      sd_lba = $urandom;
    end
    c = 0;
    while (sd_ack && c < 12000) begin
      @(negedge clk_sys);
      img_mounted = 1'b0;
      if (c == mount_at) begin
        img_size    = mount_size;
        img_mounted = 1'b1;
        m_size      = mount_size;
      end
      c++;
    end
    img_mounted = 1'b0;
    check("ack_fall", sd_ack, 1'b0);
    check("dout_left", exp_rd_q.size() + exp_din_q.size(), 0);
    check("mem_left", exp_mrd_q.size() + exp_mwr_q.size(), 0);
    repeat (hold) @(negedge clk_sys);
    sd_rd = 1'b0;
    sd_wr = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("err_count", err_seen, blocked ? 1 : 0);
    check("ack_count", ack_rises - rises0, 1);
    exp_rd_q.delete();
    exp_mrd_q.delete();
    exp_mwr_q.delete();
    exp_din_q.delete();
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  bit          r_rd;
  logic [31:0] r_lba;
  int          r_mid, c0, d0;

  initial begin
    reset_n     = 1'b0;
    sd_lba      = '0;
    sd_rd       = 1'b0;
    sd_wr       = 1'b0;
    img_mounted = 1'b0;
    img_size    = '0;
    img_wp      = 1'b0;
    m_size      = '0;
    spurious_en = 1'b1;
    repeat (3) @(negedge clk_sys);
    check("rst_ack", sd_ack, 1'b0);
    check("rst_strobes", {sd_dout_strobe, sd_din_strobe, mem_rd, mem_wr, err}, 5'b0);
    check("rst_buff_addr", sd_buff_addr, 9'd0);
    check("rst_mem_addr", mem_addr, '0);
    reset_n = 1'b1;

    mount(32'd4096);

    // LBA 2 read: byte i is (1024 + i) & 8'hFF.
    xfer(1'b1, 1'b0, 32'd2, 0, -1, 32'd0);
    check("lba2_byte300", cap_b300, 8'h2C);
    check("lba2_byte511", cap_b511, 8'hFF);

    // LBA 1 write of ~index, then read it back.
    wr_seen = 1'b0;
    xfer(1'b0, 1'b1, 32'd1, 0, -1, 32'd0);
    check("wr_first_addr", cap_first_wa, 25'd512);
    check("wr_first_data", cap_first_wd, 8'hFF);
    check("wr_last_addr", cap_last_wa, 25'd1023);
    check("wr_last_data", cap_last_wd, 8'h00);
    xfer(1'b1, 1'b0, 32'd1, 0, -1, 32'd0);
    check("lba1_readback300", cap_b300, 8'hD3);

    // LBA 8 is past a 4096-byte image.
    c0 = mrd_cnt;
    xfer(1'b1, 1'b0, 32'd8, 0, -1, 32'd0);
    check("oor_no_mem_rd", mrd_cnt - c0, 0);

    // Both requests with write protect: read wins, then a write is refused.
    img_wp = 1'b1;
    xfer(1'b1, 1'b1, 32'd4, 0, -1, 32'd0);
    d0 = din_strobes;
    xfer(1'b0, 1'b1, 32'd4, 0, -1, 32'd0);
    check("wp_din_strobes", din_strobes - d0, 512);
    img_wp = 1'b0;

    // Request held long after completion yields exactly one transfer.
    xfer(1'b1, 1'b0, 32'd5, 2000, -1, 32'd0);

    // Size boundary: last whole sector, then a truncated last sector.
    xfer(1'b1, 1'b0, 32'd7, 0, -1, 32'd0);
    mount(32'd4095);
    xfer(1'b1, 1'b0, 32'd7, 0, -1, 32'd0);
    mount(32'd4096);

    // Remount mid-transfer changes the size but does not abort.
    xfer(1'b1, 1'b0, 32'd6, 0, 120, 32'd0);
    mount(32'd4096);

    for (int k = 0; k < 8; k++) begin
      r_rd   = 1'($urandom_range(1, 0));
      r_lba  = $urandom_range(11, 0);
      img_wp = 1'($urandom_range(3, 0) == 0);
      if ($urandom_range(2, 0) == 0) mount(sizes[$urandom_range(2, 0)]);
      r_mid  = ($urandom_range(3, 0) == 0) ? int'($urandom_range(400, 50)) : -1;
      xfer(r_rd, ~r_rd, r_lba, 0, r_mid, sizes[$urandom_range(2, 0)]);
    end
    img_wp = 1'b0;
    mount(32'd4096);

    // Reset around byte 100 of a read.
    plan(1'b1, 32'd3, r_rd);
    rd_strobes = 0;
    sd_lba = 32'd3;
    sd_rd  = 1'b1;
    c0 = 0;
    while (!sd_ack && c0 < 10) begin
      @(negedge clk_sys);
      c0++;
    end
    sd_rd = 1'b0;
    c0 = 0;
    while (rd_strobes < 101 && c0 < 2000) begin
      @(negedge clk_sys);
      c0++;
    end
    check("reached_byte100", rd_strobes >= 101, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_ack", sd_ack, 1'b0);
    check("midrst_strobes", {sd_dout_strobe, sd_din_strobe, mem_rd, mem_wr, err}, 5'b0);
    check("midrst_buff_addr", sd_buff_addr, 9'd0);
    check("midrst_dout", sd_dout, 8'h00);
    exp_rd_q.delete();
    exp_mrd_q.delete();
    m_size = '0;
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    // Stored size was cleared, so the sector is out of range until remounted.
    xfer(1'b1, 1'b0, 32'd3, 0, -1, 32'd0);
    mount(32'd4096);
    xfer(1'b1, 1'b0, 32'd3, 0, -1, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
